// File: rtl/silly_pkg.sv
// Package shared by the silly vector sequencer and its hold timer.
// Holds the sequencer state type, the default golden response table
// and the sizing constants for the stimulus sweep.
package silly_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    // Golden table: bit i is the expected response to vector i = {a,b,c}.
    localparam logic [7:0]  SILLY_EXPECTED = 8'h31;
    localparam int unsigned NUM_VECTORS    = 8;
    localparam logic [2:0]  LAST_VEC       = 3'(NUM_VECTORS - 1);

    // Hold counter width; covers HOLD_CYCLES up to 255.
    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/silly_hold_timer.sv
// Hold timer: counts the cycles the current vector has been applied.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   clr      synchronous clear to zero (wins over en)
//   en       count enable
//   last     high while the count equals HOLD_CYCLES-1
module silly_hold_timer
    import silly_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [HOLD_W-1:0] cnt_q;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + HOLD_W'(1);
        end
    end

    assign last = (cnt_q == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/silly_vector_sequencer.sv
// Silly vector sequencer: sweeps the eight 3-bit vectors {a,b,c} into a
// downstream combinational unit, holds each one HOLD_CYCLES cycles, and
// compares the response y_in against the golden table EXPECTED on the
// last cycle of each hold. Results are reported when the sweep ends.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          begin a sweep (ignored while a sweep is running)
//   y_in           response of the unit under test
//   a, b, c        registered stimulus vector, a = MSB
//   busy           sweep in progress
//   done           sweep finished; held until the next start or reset
//   pass           done with no mismatches
//   err_count      number of mismatching vectors
//   fail_mask      bit i set if vector i mismatched
module silly_vector_sequencer
    import silly_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [7:0]  EXPECTED    = SILLY_EXPECTED
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask
);

    seq_state_t state_q;
    logic [2:0] vec_q;
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_q;
    logic [7:0] mask_q;

    logic       start_acc;
    logic       cmp;
    logic       mismatch;
    logic [3:0] err_d;
    logic [7:0] mask_d;
    logic [2:0] vec_d;
    logic       last;

    // NOTE: every signal driven here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        start_acc = 1'b0;
        cmp       = 1'b0;
        mismatch  = 1'b0;
        err_d     = err_q;
        mask_d    = mask_q;
        vec_d     = vec_q + 3'd1;
        if (state_q != APPLY) begin
            start_acc = start;
        end
        if (state_q == APPLY) begin
            cmp = last;
        end
        if (cmp) begin
            mismatch = (y_in != EXPECTED[vec_q]);
        end
        if (mismatch) begin
            err_d          = err_q + 4'd1;
            mask_d[vec_q]  = 1'b1;
        end
    end

    // The timer restarts at each sweep start and after every compare,
    // so each vector gets exactly HOLD_CYCLES cycles.
    silly_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (start_acc | cmp),
        .en     (state_q == APPLY),
        .last   (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                APPLY: begin
                    if (cmp) begin
                        err_q  <= err_d;
                        mask_q <= mask_d;
                        if (vec_q != LAST_VEC) begin
                            vec_q <= vec_d;
                            abc_q <= vec_d;
                        end else begin
                            state_q <= DONE;
                            abc_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 4'd0);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE: wait for start, results stay frozen.
                    if (start_acc) begin
                        state_q <= APPLY;
                        vec_q   <= '0;
                        abc_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        mask_q  <= '0;
                    end
                end
            endcase
        end
    end

    assign {a, b, c}  = abc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_mask  = mask_q;

endmodule

// File: tb/tb_silly_vector_sequencer.sv
// Bench for silly_vector_sequencer: two instances (HOLD_CYCLES 10 and 1)
// driven by directed sweeps, checked every cycle against a sweep-level
// model, plus hand-computed expectations for the notable results.
module tb_silly_vector_sequencer;

    localparam int H10 = 10;
    localparam int H1  = 1;
    localparam logic [7:0] GOLD = 8'h31;

    typedef struct packed {
        logic [2:0] abc;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] err;
        logic [7:0] mask;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start10 = 1'b0;
    logic start1  = 1'b0;
    bit   golden_mode = 1'b1;
    bit   tie_val     = 1'b0;
    bit   cmp_en      = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic a10, b10, c10, busy10, done10, pass10, y10;
    logic [3:0] err10;
    logic [7:0] mask10;
    logic a1, b1, c1, busy1, done1, pass1, y1;
    logic [3:0] err1;
    logic [7:0] mask1;

    always #5 clk = ~clk;

    // Downstream unit: the golden sillyfunction or a tied constant.
    assign y10 = golden_mode ? ((~b10 & ~c10) | (a10 & ~b10)) : tie_val;
    assign y1  = golden_mode ? ((~b1 & ~c1) | (a1 & ~b1)) : tie_val;

    silly_vector_sequencer #(.HOLD_CYCLES(H10), .EXPECTED(GOLD)) dut10 (
        .clk(clk), .reset_n(reset_n), .start(start10), .y_in(y10),
        .a(a10), .b(b10), .c(c10), .busy(busy10), .done(done10),
        .pass(pass10), .err_count(err10), .fail_mask(mask10)
    );

    silly_vector_sequencer #(.HOLD_CYCLES(H1), .EXPECTED(GOLD)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_mask(mask1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mismatch set for a whole sweep: which vectors' responses differ from GOLD.
    function automatic logic [7:0] mismatch_mask(input bit g, input bit tv);
        logic [7:0] resp;
        bit va, vb, vc;
        resp = '0;
        for (int i = 0; i < 8; i++) begin
            va = ((i >> 2) & 1) != 0;
            vb = ((i >> 1) & 1) != 0;
            vc = (i & 1) != 0;
            resp[i] = g ? ((!vb && !vc) || (va && !vb)) : tv;
        end
        return resp ^ GOLD;
    endfunction

    // Expected outputs t cycles after the start edge of a sweep of hold h.
    function automatic obs_t model(input bit active, input int t, input int h, input logic [7:0] mm);
        obs_t r;
        int n;
        r = '0;
        if (active) begin
            if (t < 8 * h) begin
                n = t / h;            // vectors already compared
                r.abc  = 3'(n);
                r.busy = 1'b1;
                for (int i = 0; i < n; i++) r.mask[i] = mm[i];
            end else begin
                r.done = 1'b1;
                r.mask = mm;
                r.pass = (mm == 8'h00);
            end
            r.err = 4'($countones(r.mask));
        end
        return r;
    endfunction

    bit         act10 = 1'b0, act1 = 1'b0;
    int         t10 = 0, t1 = 0;
    logic [7:0] mm10 = '0, mm1 = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act10 <= 1'b0; t10 <= 0;
            act1  <= 1'b0; t1  <= 0;
        end else begin
            if (start10 && (!act10 || t10 >= 8 * H10)) begin
                act10 <= 1'b1; t10 <= 0; mm10 <= mismatch_mask(golden_mode, tie_val);
            end else if (act10 && t10 < 8 * H10) begin
                t10 <= t10 + 1;
            end
            if (start1 && (!act1 || t1 >= 8 * H1)) begin
                act1 <= 1'b1; t1 <= 0; mm1 <= mismatch_mask(golden_mode, tie_val);
            end else if (act1 && t1 < 8 * H1) begin
                t1 <= t1 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("dut10_outputs", {a10, b10, c10, busy10, done10, pass10, err10, mask10},
                  32'(model(act10, t10, H10, mm10)));
            check("dut1_outputs", {a1, b1, c1, busy1, done1, pass1, err1, mask1},
                  32'(model(act1, t1, H1, mm1)));
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the sampling edge.
    task automatic pulse10();
        start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
    endtask

    task automatic pulse1();
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done10(output int cyc);
        cyc = 0;
        while (!done10 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        #1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {a10, b10, c10, busy10, done10, pass10, err10, mask10}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy10, 1'b0);

        // Golden unit: full pass, done 80 cycles after start.
        golden_mode = 1'b1;
        pulse10();
        check("first_vector_busy", {a10, b10, c10, busy10}, 4'b0001);
        wait_done10(cyc);
        check("golden_done_cycle", cyc, 80);
        check("golden_pass", pass10, 1'b1);
        check("golden_err", err10, 4'd0);
        check("golden_mask", mask10, 8'h00);

        // y_in tied 0: vectors 0,4,5 mismatch.
        golden_mode = 1'b0; tie_val = 1'b0;
        pulse10();
        check("restart_clears_done", {done10, err10, mask10}, 13'h0);
        wait_done10(cyc);
        check("tie0_err", err10, 4'd3);
        check("tie0_mask", mask10, 8'h31);
        check("tie0_pass", pass10, 1'b0);

        // y_in tied 1: the other five vectors mismatch.
        tie_val = 1'b1;
        pulse10();
        wait_done10(cyc);
        check("tie1_err", err10, 4'd5);
        check("tie1_mask", mask10, 8'hCE);
        check("tie1_done_cycle", cyc, 80);

        // Asynchronous reset at vector 4, cycle 3.
        golden_mode = 1'b1;
        pulse10();
        repeat (4 * H10 + 3) @(posedge clk);
        #1;
        check("pre_reset_vector", {a10, b10, c10, busy10}, 4'b1001);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {a10, b10, c10, busy10, done10, pass10, err10, mask10}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        pulse10();
        wait_done10(cyc);
        check("post_reset_done_cycle", cyc, 80);
        check("post_reset_pass", {pass10, err10, mask10}, 13'h1000);

        // HOLD_CYCLES = 1: mid-sweep start ignored, DONE start reruns.
        pulse1();
        cyc = 0;
        while (!done1 && cyc < 50) begin
            if (cyc == 3) start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            cyc++;
        end
        check("h1_done_cycle", cyc, 8);
        check("h1_pass", {pass1, err1, mask1}, 13'h1000);
        golden_mode = 1'b0; tie_val = 1'b0;
        pulse1();
        check("h1_rerun_cleared", {busy1, done1, err1, mask1}, 14'h2000);
        cyc = 0;
        while (!done1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("h1_rerun_cycle", cyc, 8);
        check("h1_rerun_result", {pass1, err1, mask1}, {1'b0, 4'd3, 8'h31});

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
